ex_mem_lsu: RTL and testbench

- EX/MEM boundary block: registers EX-stage results and performs all data-memory loads and stores, then presents the write-back fields (rd, CSR) to the MEM stage.
- Runs a req/ack handshake to data memory and sign/zero-extends load data.
- Raises a stall request to hazard control while an access is outstanding.
- Reset is asynchronous, active-high. All logic is on the single clock `clk`; reset port is `rst`.

---
 rtl/ex_mem_lsu_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 49 ++++
 rtl/ex_mem_lsu.sv | 177 +++++++++++++++++
 tb/tb_ex_mem_lsu.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_mem_lsu_pkg.sv
// Shared encodings for the EX/MEM load/store unit: opcodes, funct3 codes,
// bus widths, FSM states and the access-size decode used by the lane logic.
package ex_mem_lsu_pkg;

   localparam int REG_BUS_W      = 32;
   localparam int REG_ADDR_BUS_W = 5;
   localparam int CSR_ADDR_BUS_W = 12;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACCESS = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // Unknown funct3 codes fall back to a full-word access.
   function automatic size_e access_size(input logic [2:0] funct3);
      case (funct3)
         F3_LB, F3_LBU: access_size = SZ_BYTE;
         F3_LH, F3_LHU: access_size = SZ_HALF;
         default:       access_size = SZ_WORD;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane logic for a 32-bit data port: store byte enables and lane
// replication, load extraction with sign/zero extension, misalignment check.
module lsu_align
   import ex_mem_lsu_pkg::*;
(
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_store_data,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_load_data,
   output logic        o_misaligned
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_unsigned;

   assign w_byte     = i_rdata[{i_addr, 3'b000} +: 8];
   assign w_half     = i_rdata[{i_addr[1], 4'b0000} +: 16];
   assign w_unsigned = i_funct3[2];

   // Decode access size into lane enables, replicated store data and load data.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the case leaves one unassigned and no latch is inferred.
      o_be         = 4'b1111;
      o_wdata      = i_store_data;
      o_load_data  = i_rdata;
      o_misaligned = 1'b0;
      case (access_size(i_funct3))
         SZ_BYTE: begin
            o_be        = 4'b0001 << i_addr;
            o_wdata     = {4{i_store_data[7:0]}};
            o_load_data = w_unsigned ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         end
         SZ_HALF: begin
            o_be         = 4'b0011 << i_addr;
            o_wdata      = {2{i_store_data[15:0]}};
            o_load_data  = w_unsigned ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            o_misaligned = i_addr[0];
         end
         default: begin
            o_misaligned = (i_addr != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/ex_mem_lsu.sv
// EX/MEM pipeline register with a blocking req/ack data-memory port.
// Aligned loads/stores park in ACCESS until ack and stall the pipe meanwhile.
module ex_mem_lsu
   import ex_mem_lsu_pkg::*;
#(
   parameter int XLEN   = REG_BUS_W,
   parameter int REG_AW = REG_ADDR_BUS_W,
   parameter int CSR_AW = CSR_ADDR_BUS_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              ex_valid_i,
   input  logic [6:0]        ex_opcode_i,
   input  logic [2:0]        ex_funct3_i,
   input  logic [REG_AW-1:0] ex_rd_addr_i,
   input  logic              ex_wreg_i,
   input  logic [XLEN-1:0]   ex_wdata_i,
   input  logic [XLEN-1:0]   ex_store_data_i,
   input  logic [CSR_AW-1:0] ex_csr_waddr_i,
   input  logic              ex_csr_wreg_i,
   input  logic [XLEN-1:0]   ex_csr_wdata_i,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [XLEN-1:0]   dmem_addr_o,
   output logic [3:0]        dmem_be_o,
   output logic [XLEN-1:0]   dmem_wdata_o,
   input  logic              dmem_ack_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   output logic              valid_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic              wreg_o,
   output logic [XLEN-1:0]   wdata_o,
   output logic [CSR_AW-1:0] csr_waddr_o,
   output logic              csr_wreg_o,
   output logic [XLEN-1:0]   csr_wdata_o,
   output logic              misalign_o,
   output logic              stallreq_o
);

   state_e            r_state;
   state_e            w_next_state;

   // Access context latched at the capture edge and held through ACCESS.
   logic [2:0]        r_funct3;
   logic [XLEN-1:0]   r_addr;
   logic [XLEN-1:0]   r_store_data;
   logic              r_is_store;
   logic              r_lat_wreg;
   logic              r_lat_csr_wreg;

   logic              w_access;
   logic              w_is_mem;
   logic              w_accept;
   logic [2:0]        w_al_funct3;
   logic [1:0]        w_al_addr;
   logic [3:0]        w_al_be;
   logic [31:0]       w_al_wdata;
   logic [31:0]       w_al_load;
   logic              w_al_misaligned;

   assign w_access = (r_state == ST_ACCESS);
   assign w_is_mem = (ex_opcode_i == OPC_LOAD) || (ex_opcode_i == OPC_STORE);
   // IDLE edge that actually takes a new EX instruction.
   assign w_accept = !flush_i && !stall_i && ex_valid_i;

   // The lane logic checks the incoming EX access in IDLE and drives the
   // latched access in ACCESS.
   assign w_al_funct3 = w_access ? r_funct3    : ex_funct3_i;
   assign w_al_addr   = w_access ? r_addr[1:0] : ex_wdata_i[1:0];

   lsu_align u_align (
      .i_funct3     (w_al_funct3),
      .i_addr       (w_al_addr),
      .i_store_data (r_store_data),
      .i_rdata      (dmem_rdata_i),
      .o_be         (w_al_be),
      .o_wdata      (w_al_wdata),
      .o_load_data  (w_al_load),
      .o_misaligned (w_al_misaligned)
   );

   // Memory port is driven purely from the state register, so an async reset
   // drops the request immediately.
   assign dmem_req_o   = w_access;
   assign stallreq_o   = w_access;
   assign dmem_we_o    = w_access && r_is_store;
   assign dmem_addr_o  = w_access ? {r_addr[XLEN-1:2], 2'b00} : '0;
   assign dmem_be_o    = !w_access ? 4'b0000 : (r_is_store ? w_al_be : 4'b1111);
   assign dmem_wdata_o = (w_access && r_is_store) ? w_al_wdata : '0;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state: enter ACCESS on an aligned load/store, leave on ack.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_is_mem && !w_al_misaligned) w_next_state = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (dmem_ack_i) w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // MEM-stage output registers and the latched access context.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_o        <= 1'b0;
         rd_addr_o      <= '0;
         wreg_o         <= 1'b0;
         wdata_o        <= '0;
         csr_waddr_o    <= '0;
         csr_wreg_o     <= 1'b0;
         csr_wdata_o    <= '0;
         misalign_o     <= 1'b0;
         r_funct3       <= '0;
         r_addr         <= '0;
         r_store_data   <= '0;
         r_is_store     <= 1'b0;
         r_lat_wreg     <= 1'b0;
         r_lat_csr_wreg <= 1'b0;
      end else if (r_state == ST_IDLE) begin
         if (flush_i || (!stall_i && !ex_valid_i)) begin
            valid_o    <= 1'b0;
            wreg_o     <= 1'b0;
            csr_wreg_o <= 1'b0;
            misalign_o <= 1'b0;
         end else if (!stall_i) begin
            rd_addr_o   <= ex_rd_addr_i;
            wdata_o     <= ex_wdata_i;
            csr_waddr_o <= ex_csr_waddr_i;
            csr_wdata_o <= ex_csr_wdata_i;
            if (!w_is_mem) begin
               valid_o    <= 1'b1;
               wreg_o     <= ex_wreg_i;
               csr_wreg_o <= ex_csr_wreg_i;
               misalign_o <= 1'b0;
            end else if (w_al_misaligned) begin
               // Faulting access: flagged, never reaches memory, no writes.
               valid_o    <= 1'b1;
               wreg_o     <= 1'b0;
               csr_wreg_o <= 1'b0;
               misalign_o <= 1'b1;
            end else begin
               // Bubble now; the result appears on the ack edge.
               valid_o        <= 1'b0;
               wreg_o         <= 1'b0;
               csr_wreg_o     <= 1'b0;
               misalign_o     <= 1'b0;
               r_funct3       <= ex_funct3_i;
               r_addr         <= ex_wdata_i;
               r_store_data   <= ex_store_data_i;
               r_is_store     <= (ex_opcode_i == OPC_STORE);
               r_lat_wreg     <= ex_wreg_i;
               r_lat_csr_wreg <= ex_csr_wreg_i;
            end
         end
      end else if (dmem_ack_i) begin
         // Ack edge: the access is committed regardless of stall/flush.
         valid_o    <= 1'b1;
         wreg_o     <= r_is_store ? 1'b0 : r_lat_wreg;
         wdata_o    <= r_is_store ? r_addr : w_al_load;
         csr_wreg_o <= r_lat_csr_wreg;
         misalign_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_mem_lsu.sv
// Directed bench for ex_mem_lsu: single-cycle vector table, then hand-written
// load/store sequences with variable ack latency and an async reset mid-access.
module tb_ex_mem_lsu;

   localparam logic [6:0] OP_ALU = 7'h33;
   localparam logic [6:0] OP_SYS = 7'h73;
   localparam logic [6:0] OP_LD  = 7'h03;
   localparam logic [6:0] OP_ST  = 7'h23;

   logic        clk;
   logic        rst;
   logic        stall_i, flush_i, ex_valid_i;
   logic [6:0]  ex_opcode_i;
   logic [2:0]  ex_funct3_i;
   logic [4:0]  ex_rd_addr_i;
   logic        ex_wreg_i;
   logic [31:0] ex_wdata_i, ex_store_data_i;
   logic [11:0] ex_csr_waddr_i;
   logic        ex_csr_wreg_i;
   logic [31:0] ex_csr_wdata_i;
   logic        dmem_req_o, dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic        dmem_ack_i;
   logic [31:0] dmem_rdata_i;
   logic        valid_o;
   logic [4:0]  rd_addr_o;
   logic        wreg_o;
   logic [31:0] wdata_o;
   logic [11:0] csr_waddr_o;
   logic        csr_wreg_o;
   logic [31:0] csr_wdata_o;
   logic        misalign_o, stallreq_o;

   int n_checks = 0;
   int n_errors = 0;

   ex_mem_lsu dut (
      .clk             (clk),
      .rst             (rst),
      .stall_i         (stall_i),
      .flush_i         (flush_i),
      .ex_valid_i      (ex_valid_i),
      .ex_opcode_i     (ex_opcode_i),
      .ex_funct3_i     (ex_funct3_i),
      .ex_rd_addr_i    (ex_rd_addr_i),
      .ex_wreg_i       (ex_wreg_i),
      .ex_wdata_i      (ex_wdata_i),
      .ex_store_data_i (ex_store_data_i),
      .ex_csr_waddr_i  (ex_csr_waddr_i),
      .ex_csr_wreg_i   (ex_csr_wreg_i),
      .ex_csr_wdata_i  (ex_csr_wdata_i),
      .dmem_req_o      (dmem_req_o),
      .dmem_we_o       (dmem_we_o),
      .dmem_addr_o     (dmem_addr_o),
      .dmem_be_o       (dmem_be_o),
      .dmem_wdata_o    (dmem_wdata_o),
      .dmem_ack_i      (dmem_ack_i),
      .dmem_rdata_i    (dmem_rdata_i),
      .valid_o         (valid_o),
      .rd_addr_o       (rd_addr_o),
      .wreg_o          (wreg_o),
      .wdata_o         (wdata_o),
      .csr_waddr_o     (csr_waddr_o),
      .csr_wreg_o      (csr_wreg_o),
      .csr_wdata_o     (csr_wdata_o),
      .misalign_o      (misalign_o),
      .stallreq_o      (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush, stall, valid;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        wreg;
      logic [31:0] wdata;
      logic [11:0] caddr;
      logic        cwreg;
      logic [31:0] cwdata;
   } in_t;

   typedef struct {
      logic        valid, wreg, cwreg, mis, chk;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic [11:0] caddr;
      logic [31:0] cwdata;
   } exp_t;

   typedef struct {
      in_t  i;
      exp_t e;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive_ex(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                           input logic wreg, input logic [31:0] wdata, input logic [31:0] sdata);
      ex_valid_i      = 1'b1;
      ex_opcode_i     = opc;
      ex_funct3_i     = f3;
      ex_rd_addr_i    = rd;
      ex_wreg_i       = wreg;
      ex_wdata_i      = wdata;
      ex_store_data_i = sdata;
      ex_csr_waddr_i  = 12'h0;
      ex_csr_wreg_i   = 1'b0;
      ex_csr_wdata_i  = 32'h0;
   endtask

   // One load/store: capture edge, n_acc ACCESS cycles with ack on the last.
   task automatic mem_op(input string name, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                         input int n_acc, input logic hz, input logic [3:0] e_be,
                         input logic [31:0] e_dwdata, input logic [31:0] e_result, input logic e_wreg);
      int          stall_cnt;
      logic        stable;
      logic [31:0] e_addr;
      e_addr = {addr[31:2], 2'b00};
      drive_ex(opc, f3, 5'd4, 1'b1, addr, sdata);
      @(posedge clk); #1;
      ex_valid_i = 1'b0;
      flush_i    = hz;
      stall_i    = hz;
      check({name, " req"},   {31'h0, dmem_req_o}, 32'h1);
      check({name, " bubble"}, {31'h0, valid_o},   32'h0);
      check({name, " addr"},  dmem_addr_o, e_addr);
      check({name, " be"},    {28'h0, dmem_be_o}, {28'h0, e_be});
      check({name, " we"},    {31'h0, dmem_we_o}, {31'h0, (opc == OP_ST)});
      if (opc == OP_ST) check({name, " dwdata"}, dmem_wdata_o, e_dwdata);
      stall_cnt = 0;
      stable    = 1'b1;
      for (int i = 0; i < n_acc; i++) begin
         if (stallreq_o) stall_cnt++;
         if (!dmem_req_o || dmem_addr_o !== e_addr || dmem_be_o !== e_be) stable = 1'b0;
         if (i == n_acc - 1) begin
            dmem_ack_i   = 1'b1;
            dmem_rdata_i = rdata;
         end
         @(posedge clk); #1;
         dmem_ack_i   = 1'b0;
         dmem_rdata_i = 32'h0;
      end
      flush_i = 1'b0;
      stall_i = 1'b0;
      check({name, " stall cycles"}, stall_cnt, n_acc);
      check({name, " port stable"}, {31'h0, stable}, 32'h1);
      check({name, " valid"},  {31'h0, valid_o},    32'h1);
      check({name, " wreg"},   {31'h0, wreg_o},     {31'h0, e_wreg});
      check({name, " rd"},     {27'h0, rd_addr_o},  32'd4);
      check({name, " mis"},    {31'h0, misalign_o}, 32'h0);
      check({name, " req off"}, {31'h0, dmem_req_o}, 32'h0);
      if (opc == OP_LD) check({name, " result"}, wdata_o, e_result);
   endtask

   initial begin
      // flush, stall, valid, opc, f3, rd, wreg, wdata, caddr, cwreg, cwdata
      // valid, wreg, cwreg, mis, chk, rd, wdata, caddr, cwdata
      vecs[0].i  = '{1'b0, 1'b0, 1'b1, OP_ALU, 3'd0, 5'd5, 1'b1, 32'h1234, 12'h0, 1'b0, 32'h0};
      vecs[0].e  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 12'h0, 32'h0};
      vecs[1].i  = '{1'b0, 1'b0, 1'b0, OP_ALU, 3'd0, 5'd6, 1'b1, 32'h9, 12'h0, 1'b0, 32'h0};
      vecs[1].e  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 12'h0, 32'h0};
      vecs[2].i  = '{1'b0, 1'b0, 1'b1, OP_SYS, 3'd1, 5'd7, 1'b1, 32'h55, 12'h300, 1'b1, 32'hDEAD};
      vecs[2].e  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h55, 12'h300, 32'hDEAD};
      vecs[3].i  = '{1'b0, 1'b1, 1'b1, OP_ALU, 3'd0, 5'd9, 1'b1, 32'h99, 12'h0, 1'b0, 32'h0};
      vecs[3].e  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 32'h55, 12'h300, 32'hDEAD};
      vecs[4].i  = '{1'b1, 1'b1, 1'b1, OP_ALU, 3'd0, 5'd9, 1'b1, 32'h99, 12'h0, 1'b1, 32'h0};
      vecs[4].e  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 12'h0, 32'h0};
      vecs[5].i  = '{1'b0, 1'b0, 1'b1, OP_LD, 3'd2, 5'd3, 1'b1, 32'h101, 12'h0, 1'b1, 32'h0};
      vecs[5].e  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 12'h0, 32'h0};
      vecs[6].i  = '{1'b0, 1'b0, 1'b1, OP_LD, 3'd1, 5'd3, 1'b1, 32'h203, 12'h0, 1'b0, 32'h0};
      vecs[6].e  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 12'h0, 32'h0};
      vecs[7].i  = '{1'b0, 1'b0, 1'b1, OP_ST, 3'd2, 5'd0, 1'b0, 32'h102, 12'h0, 1'b0, 32'h0};
      vecs[7].e  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 12'h0, 32'h0};
      vecs[8].i  = '{1'b0, 1'b0, 1'b1, OP_ST, 3'd1, 5'd0, 1'b0, 32'h201, 12'h0, 1'b0, 32'h0};
      vecs[8].e  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 12'h0, 32'h0};
      vecs[9].i  = '{1'b0, 1'b0, 1'b1, OP_LD, 3'd5, 5'd8, 1'b1, 32'h105, 12'h0, 1'b0, 32'h0};
      vecs[9].e  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 12'h0, 32'h0};
      vecs[10].i = '{1'b0, 1'b0, 1'b1, OP_ALU, 3'd0, 5'd2, 1'b1, 32'hCAFE, 12'h5, 1'b0, 32'h0};
      vecs[10].e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 32'hCAFE, 12'h5, 32'h0};

      rst          = 1'b1;
      stall_i      = 1'b0;
      flush_i      = 1'b0;
      dmem_ack_i   = 1'b0;
      dmem_rdata_i = 32'h0;
      drive_ex(OP_ALU, 3'd0, 5'd0, 1'b0, 32'h0, 32'h0);
      ex_valid_i   = 1'b0;
      #1;
      check("reset valid",    {31'h0, valid_o},    32'h0);
      check("reset req",      {31'h0, dmem_req_o}, 32'h0);
      check("reset stallreq", {31'h0, stallreq_o}, 32'h0);
      check("reset misalign", {31'h0, misalign_o}, 32'h0);
      check("reset wdata",    wdata_o, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int k = 0; k < 11; k++) begin
         flush_i        = vecs[k].i.flush;
         stall_i        = vecs[k].i.stall;
         ex_valid_i     = vecs[k].i.valid;
         ex_opcode_i    = vecs[k].i.opc;
         ex_funct3_i    = vecs[k].i.f3;
         ex_rd_addr_i   = vecs[k].i.rd;
         ex_wreg_i      = vecs[k].i.wreg;
         ex_wdata_i     = vecs[k].i.wdata;
         ex_csr_waddr_i = vecs[k].i.caddr;
         ex_csr_wreg_i  = vecs[k].i.cwreg;
         ex_csr_wdata_i = vecs[k].i.cwdata;
         @(posedge clk); #1;
         check($sformatf("vec%0d valid", k),    {31'h0, valid_o},    {31'h0, vecs[k].e.valid});
         check($sformatf("vec%0d wreg", k),     {31'h0, wreg_o},     {31'h0, vecs[k].e.wreg});
         check($sformatf("vec%0d csr_wreg", k), {31'h0, csr_wreg_o}, {31'h0, vecs[k].e.cwreg});
         check($sformatf("vec%0d misalign", k), {31'h0, misalign_o}, {31'h0, vecs[k].e.mis});
         check($sformatf("vec%0d req", k),      {31'h0, dmem_req_o}, 32'h0);
         check($sformatf("vec%0d stallreq", k), {31'h0, stallreq_o}, 32'h0);
         if (vecs[k].e.chk) begin
            check($sformatf("vec%0d rd", k),        {27'h0, rd_addr_o},   {27'h0, vecs[k].e.rd});
            check($sformatf("vec%0d wdata", k),     wdata_o,              vecs[k].e.wdata);
            check($sformatf("vec%0d csr_waddr", k), {20'h0, csr_waddr_o}, {20'h0, vecs[k].e.caddr});
            check($sformatf("vec%0d csr_wdata", k), csr_wdata_o,          vecs[k].e.cwdata);
         end
      end
      flush_i = 1'b0;
      stall_i = 1'b0;

      //     name   opc    f3    addr       sdata         rdata         n  hz    be       dwdata        result        wreg
      mem_op("LB",  OP_LD, 3'd0, 32'h103,   32'h0,        32'h80FF_FF00, 3, 1'b0, 4'b1111, 32'h0,        32'hFFFF_FF80, 1'b1);
      mem_op("SH",  OP_ST, 3'd1, 32'h202,   32'h0000_ABCD, 32'h0,        1, 1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0,        1'b0);
      mem_op("LWHZ", OP_LD, 3'd2, 32'h300,  32'h0,        32'h1234_5678, 2, 1'b1, 4'b1111, 32'h0,        32'h1234_5678, 1'b1);
      mem_op("LH",  OP_LD, 3'd1, 32'h302,   32'h0,        32'h8001_0000, 1, 1'b0, 4'b1111, 32'h0,        32'hFFFF_8001, 1'b1);
      mem_op("LHU", OP_LD, 3'd5, 32'h302,   32'h0,        32'h8001_0000, 1, 1'b0, 4'b1111, 32'h0,        32'h0000_8001, 1'b1);
      mem_op("SB",  OP_ST, 3'd0, 32'h101,   32'h1234_565A, 32'h0,        2, 1'b0, 4'b0010, 32'h5A5A_5A5A, 32'h0,        1'b0);
      mem_op("SW",  OP_ST, 3'd2, 32'h104,   32'hDEAD_BEEF, 32'h0,        1, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0);

      // Async reset in the middle of an ACCESS.
      drive_ex(OP_LD, 3'd2, 5'd11, 1'b1, 32'h400, 32'h0);
      @(posedge clk); #1;
      ex_valid_i = 1'b0;
      check("rstacc req before", {31'h0, dmem_req_o}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("rstacc req",      {31'h0, dmem_req_o}, 32'h0);
      check("rstacc stallreq", {31'h0, stallreq_o}, 32'h0);
      check("rstacc addr",     dmem_addr_o, 32'h0);
      check("rstacc valid",    {31'h0, valid_o},    32'h0);
      check("rstacc rd",       {27'h0, rd_addr_o},  32'h0);
      check("rstacc wdata",    wdata_o, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post-rst idle req", {31'h0, dmem_req_o}, 32'h0);
      mem_op("LBU", OP_LD, 3'd4, 32'h0, 32'h0, 32'h0000_00F0, 1, 1'b0, 4'b1111, 32'h0, 32'h0000_00F0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
